y_seq_ctrl: RTL

Multicycle sequencer for the y-series MIPS-subset datapath (yIF/yID/yEX/yDM/yWB/yPC). It replaces the combinational yC1–yC4 decode with a registered finite-state machine (FSM). The FSM issues one datapath phase per cycle and stalls on a memory ready handshake. It takes interrupts only at instruction boundaries, redirecting the PC to `entryPoint` through yPC.

---
 rtl/y_pkg.sv | 40 ++++
 rtl/y_alu_dec.sv | 43 ++++
 rtl/y_seq_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/y_pkg.sv
// Shared definitions for the y-series multicycle sequencer: FSM states,
// instruction field encodings and ALU operation codes.
package y_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_INTR   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Opcodes that continue past DECODE; everything else (j, NOPs) retires there.
    function automatic logic needs_exec(input logic [5:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_LW) || (opc == OPC_SW) ||
               (opc == OPC_BEQ) || (opc == OPC_ADDI);
    endfunction

endpackage

// File: rtl/y_alu_dec.sv
// ALU operation decode. The op is only driven while the ALU is in use
// (EXEC and MEM address phase); elsewhere it rests at 000.
module y_alu_dec
    import y_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_fn_code,
    input  state_t     i_state,
    output logic [2:0] o_op,
    output logic       o_fn_valid
);

    logic [2:0] w_rtype_op;

    always_comb begin
        w_rtype_op = ALU_ADD;
        o_fn_valid = 1'b1;
        case (i_fn_code)
            FN_ADD:  w_rtype_op = ALU_ADD;
            FN_SUB:  w_rtype_op = ALU_SUB;
            FN_AND:  w_rtype_op = ALU_AND;
            FN_OR:   w_rtype_op = ALU_OR;
            FN_SLT:  w_rtype_op = ALU_SLT;
            default: begin
                w_rtype_op = ALU_ADD;
                o_fn_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_op = ALU_AND;
        if (i_state == S_EXEC || i_state == S_MEM) begin
            case (i_opcode)
                OPC_RTYPE:                  o_op = w_rtype_op;
                OPC_BEQ:                    o_op = ALU_SUB;
                OPC_LW, OPC_SW, OPC_ADDI:   o_op = ALU_ADD;
                default:                    o_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/y_seq_ctrl.sv
// Multicycle control FSM for the y-series datapath: one phase per cycle,
// memory-ready stalls with a timeout, interrupts taken at instruction boundaries.
//
//  state  | meaning
//  FETCH  | read instruction, wait for mem_ready, load IR and PC+4
//  DECODE | j / NOP retire here, others go on
//  EXEC   | ALU phase; beq resolves and retires
//  MEM    | lw/sw data access, wait for mem_ready
//  WB     | register write-back, retire
//  INTR   | redirect PC to entryPoint, acknowledge interrupt
//  HALT   | memory timeout; only rst leaves
module y_seq_ctrl
    import y_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] fnCode,
    input  logic       zero,
    input  logic       INT,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Mem2Reg,
    output logic       branch,
    output logic       jump,
    output logic       int_sel,
    output logic [2:0] op,
    output logic       int_ack,
    output logic       retire,
    output logic       mem_err
);

    // Timeout fires on the stalled cycle that would bring the count to MAX_WAIT.
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_t     r_state;
    state_t     w_next;
    state_t     w_boundary;
    logic [3:0] r_wait;
    logic       r_int_pend;
    logic       r_mem_err;
    logic       w_stall;
    logic       w_timeout;
    logic       w_is_lw;
    logic       w_is_sw;
    logic [2:0] w_alu_op;
    logic       w_fn_valid;

    assign w_is_lw    = (opcode == OPC_LW);
    assign w_is_sw    = (opcode == OPC_SW);
    assign w_stall    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
    assign w_timeout  = w_stall && (r_wait == WAIT_LAST);
    // A request arriving in the retiring cycle itself is taken at this boundary.
    assign w_boundary = (r_int_pend || INT) ? S_INTR : S_FETCH;

    y_alu_dec u_alu_dec (
        .i_opcode   (opcode),
        .i_fn_code  (fnCode),
        .i_state    (r_state),
        .o_op       (w_alu_op),
        .o_fn_valid (w_fn_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait     <= 4'd0;
            r_int_pend <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_wait     <= w_stall ? r_wait + 4'd1 : 4'd0;
            r_int_pend <= (r_state == S_INTR) ? INT : (r_int_pend || INT);
            if (w_timeout) r_mem_err <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_HALT;
            end
            S_DECODE: w_next = needs_exec(opcode) ? S_EXEC : w_boundary;
            S_EXEC: begin
                if (opcode == OPC_BEQ)     w_next = w_boundary;
                else if (w_is_lw || w_is_sw) w_next = S_MEM;
                else                       w_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready)      w_next = w_is_lw ? S_WB : w_boundary;
                else if (w_timeout) w_next = S_HALT;
            end
            S_WB:    w_next = w_boundary;
            S_INTR:  w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        ir_write = 1'b0;
        pc_write = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Mem2Reg  = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        int_sel  = 1'b0;
        op       = 3'b000;
        int_ack  = 1'b0;
        retire   = 1'b0;
        mem_err  = r_mem_err && !rst;
        // Reset silences everything in the same cycle, e.g. aborting a store in MEM.
        if (!rst) begin
            op = w_alu_op;
            case (r_state)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    if (opcode == OPC_J) begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else if (!needs_exec(opcode)) begin
                        retire = 1'b1;
                    end
                end
                S_EXEC: begin
                    ALUSrc = w_is_lw || w_is_sw || (opcode == OPC_ADDI);
                    if (opcode == OPC_BEQ) begin
                        branch   = 1'b1;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    ALUSrc   = 1'b1;
                    MemRead  = w_is_lw;
                    MemWrite = w_is_sw;
                    retire   = w_is_sw && mem_ready;
                end
                S_WB: begin
                    RegWrite = (opcode != OPC_RTYPE) || w_fn_valid;
                    RegDst   = (opcode == OPC_RTYPE);
                    Mem2Reg  = w_is_lw;
                    retire   = 1'b1;
                end
                S_INTR: begin
                    int_sel  = 1'b1;
                    pc_write = 1'b1;
                    int_ack  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
